// File: rtl/wb_slave_burst.sv
// Wishbone B4 slave bridging to a local request/ready port, with registered incrementing
// bursts and an access timeout. Define WB_SLAVE_RETRY_EN to report timeouts as retry.
module wb_slave_burst #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TAGSIZE = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic [TAGSIZE-1:0]  wb_tgd_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [TAGSIZE-1:0]  wb_tgd_o,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [TAGSIZE-1:0]  wb_tga_i,
    input  logic                wb_cyc_i,
    input  logic [TAGSIZE-1:0]  wb_tgc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic [2:0]          wb_cti_i,
    input  logic [1:0]          wb_bte_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_rty_o,
    output logic                req_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                we_o,
    output logic [DATA_W/8-1:0] sel_o,
    output logic [DATA_W-1:0]   data_o,
    output logic [TAGSIZE-1:0]  tag_o,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                ready_i,
    input  logic                err_i
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWait, StResp, StFail} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [TAGSIZE-1:0]  tag_q, tag_d;
    logic [TAGSIZE-1:0]  tgc_q, tgc_d;
    logic [2:0]          cti_q, cti_d;
    logic [1:0]          bte_q, bte_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                rty_q, rty_d;

    // The data tag has no local counterpart.
    logic unused_tgd;
    assign unused_tgd = ^wb_tgd_i;

    // Wrapping bursts only move the beat-index bits; everything above stays put.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0]        bte);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc = a + ADDR_W'(SEL_W);
        case (bte)
            2'b01:   mask = ADDR_W'(4 * SEL_W - 1);
            2'b10:   mask = ADDR_W'(8 * SEL_W - 1);
            2'b11:   mask = ADDR_W'(16 * SEL_W - 1);
            default: mask = '1;
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        data_d  = data_q;
        tag_d   = tag_q;
        tgc_d   = tgc_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d  = wb_adr_i;
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    data_d  = wb_dat_i;
                    tag_d   = wb_tga_i;
                    tgc_d   = wb_tgc_i;
                    cti_d   = wb_cti_i;
                    bte_d   = wb_bte_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!wb_cyc_i) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                end else if (ready_i) begin
                    req_d = 1'b0;
                    if (err_i) begin
                        err_d   = 1'b1;
                        state_d = StFail;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = StResp;
                        if (!we_q) begin
                            rdat_d = data_i;
                        end
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    state_d = StFail;
`ifdef WB_SLAVE_RETRY_EN
                    rty_d   = 1'b1;
`else
                    err_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (cti_q == 3'b010 && wb_cyc_i && wb_stb_i) begin
                    addr_d  = next_addr(addr_q, bte_q);
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    data_d  = wb_dat_i;
                    cti_d   = wb_cti_i;
                    bte_d   = wb_bte_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    state_d = StIdle;
                end
            end
            // StFail: the err/rty pulse cycle; the bus request is not re-sampled here.
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            tgc_q   <= '0;
            cti_q   <= '0;
            bte_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            tgc_q   <= tgc_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_tgd_o = tgc_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = rty_q;
    assign req_o    = req_q;
    assign addr_o   = addr_q;
    assign we_o     = we_q;
    assign sel_o    = sel_q;
    assign data_o   = data_q;
    assign tag_o    = tag_q;

endmodule
